array_port_arbiter: RTL
=======================

# array_port_arbiter

Two-requester arbiter and access controller for a banked two-dimensional register array, organized as rows 0..ROWS-1 by columns 1..COLS. Requests are granted round-robin, one per cycle. Out-of-range addresses are dropped and flagged, never aliased. A watch counter counts value changes of one selected bit of one selected cell. The block sits between the requesting engines and the shared table storage, and owns that storage.

## Interface
- ROWS, 4: number of rows, indexed 0..ROWS-1
- COLS, 2: number of columns, indexed 1..COLS (base 1)
- WIDTH, 8: word width
- AW, 8: width of the row and column address ports; wide enough to express out-of-range indices
- WATCH_ROW, 2 / WATCH_COL, 2 / WATCH_BIT, 3: the watched cell and bit
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- a_req, b_req  in  1  request valid, held until acked
- a_we, b_we  in  1  1 = write, 0 = read
- a_row, b_row, a_col, b_col  in  AW  cell address
- a_wdata, b_wdata  in  WIDTH  write data
- a_ack, b_ack  out  1  request accepted this cycle (combinational)
- a_rvalid, b_rvalid  out  1  read data valid (registered)
- a_rdata, b_rdata  out  WIDTH  read data
- a_err, b_err  out  1  the accepted request was out of range (registered)
- watch_cnt  out  8  change count of the watched bit

## Operation
- Arbitration: a one-bit round-robin pointer `prio` selects the preferred requester.
  - Only one requester active: it is granted.
  - Both active: the `prio` side is granted, and `prio` flips to the other side.
  - A grant with no contention leaves `prio` unchanged.
  - At most one ack per cycle.
- Handshake: a request must stay stable while req=1 and ack=0. The requester may drop req only after ack. The same requester may issue a new request in the cycle after its ack.
- Range check: the address is valid iff row < ROWS and 1 <= col <= COLS. Compare at full AW width with no truncation; for example, row 66 with ROWS=4 is invalid.
- Valid write: storage[row][col] <= wdata at the ack edge.
- Invalid write: storage is unchanged and err pulses.
- Valid read: rdata = storage[row][col] as sampled at the ack edge, so it reflects writes completed before that edge.
- Invalid read: rdata = 0, and rvalid and err pulse together.
- Watch counter: watch_cnt increments by 1 on an accepted valid write to (WATCH_ROW, WATCH_COL) where new[WATCH_BIT] != old[WATCH_BIT].
  - Writes that leave that bit unchanged do not count.
  - Writes to other cells do not count.
  - The counter wraps from 255 to 0.
- Storage is internal. Every access goes through the arbiter; there is no bypass path.

## Timing
- Reset values: storage all 0, prio=0 (A preferred), watch_cnt=0, and all of a_rvalid, b_rvalid, a_err, b_err, a_rdata, b_rdata = 0. The ack outputs are 0 whenever rst=1.
- Write latency: the write is visible to a read acked in the following cycle.
- Read latency: rvalid, rdata and err are asserted 1 cycle after ack, for exactly 1 cycle.
  - rdata holds its value until the next read response for that side.
  - err clears to 0 on the next response.
- Back-to-back: one response is possible per cycle for each side. A and B responses never occur in the same cycle.
- watch_cnt updates in the same edge as the write. The new value is visible 1 cycle after ack.
- Reset mid-operation: a pending response is discarded with no rvalid, and the arbiter restarts with prio=0.
- Same cell targeted by both requesters in one cycle: only the granted side's access happens. The other side is served later, in order.

## Structure
- Package `array_arb_pkg`: a typedef for the requester id (A/B), a range-check function in_range(row, col), and the default geometry constants.
- Sub-module `rr_arb2`: a two-input round-robin arbiter with the prio register, outputs grant[1:0]. Instantiate it once.
- Storage, the response registers and the watch logic stay in the top module.

## Test plan
- Reset, then A writes 7 to (2,1) and 8 to (2,2), then reads both. Required: rdata 7 then 8, err=0, and watch_cnt=1 because bit 3 of (2,2) went from 0 to 1.
- A writes 6 to (66,1), then reads (2,1). Required: err pulses on the write, the read returns 7, and no cell is modified.
- A writes 5 to (1,0), then reads (1,3). Required: both accesses give err=1, and the read returns rdata=0.
- A and B both request continuously for 6 cycles. Required: acks alternate A,B,A,B,A,B, with no cycle carrying two acks.
- Write 0x08, then 0x0C, then 0x00 to (2,2). Required: watch_cnt rises from 1 to 2, since 0x0C leaves bit 3 unchanged and only the clear to 0x00 counts.
- Assert rst in the cycle after a read ack. Required: no rvalid appears, storage reads 0 afterward, and watch_cnt=0.

Source files
------------

// File: rtl/array_arb_pkg.sv
// Shared types, default geometry and the address range check for array_port_arbiter.
package array_arb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  localparam int unsigned DEF_ROWS      = 4;
  localparam int unsigned DEF_COLS      = 2;
  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_AW        = 8;
  localparam int unsigned DEF_WATCH_ROW = 2;
  localparam int unsigned DEF_WATCH_COL = 2;
  localparam int unsigned DEF_WATCH_BIT = 3;

  // Addresses are widened to this before comparing so no high bits are lost.
  localparam int unsigned ADDR_MAX_W = 64;

  function automatic logic in_range(input logic [ADDR_MAX_W-1:0] row,
                                    input logic [ADDR_MAX_W-1:0] col,
                                    input int unsigned           rows,
                                    input int unsigned           cols);
    return (row < ADDR_MAX_W'(rows)) && (col != '0) && (col <= ADDR_MAX_W'(cols));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the priority pointer only moves on contention.
module rr_arb2
  import array_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  req_id_t r_prio;
  logic    w_both;

  assign w_both = i_req[0] & i_req[1];

  always_comb begin
    o_grant = '0;
    if (!rst) begin
      if (w_both) o_grant = (r_prio == REQ_A) ? 2'b01 : 2'b10;
      else        o_grant = i_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_prio <= REQ_A;
    else if (w_both) r_prio <= (r_prio == REQ_A) ? REQ_B : REQ_A;
  end

endmodule

// File: rtl/array_port_arbiter.sv
// Two-port arbitrated access to an internal ROWS x COLS (columns base 1) register table,
// with range-checked accesses and a change counter on one watched bit.
module array_port_arbiter
  import array_arb_pkg::*;
#(
  parameter int unsigned ROWS      = DEF_ROWS,
  parameter int unsigned COLS      = DEF_COLS,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned AW        = DEF_AW,
  parameter int unsigned WATCH_ROW = DEF_WATCH_ROW,
  parameter int unsigned WATCH_COL = DEF_WATCH_COL,
  parameter int unsigned WATCH_BIT = DEF_WATCH_BIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic             b_req,
  input  logic             a_we,
  input  logic             b_we,
  input  logic [AW-1:0]    a_row,
  input  logic [AW-1:0]    b_row,
  input  logic [AW-1:0]    a_col,
  input  logic [AW-1:0]    b_col,
  input  logic [WIDTH-1:0] a_wdata,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             a_ack,
  output logic             b_ack,
  output logic             a_rvalid,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  output logic [WIDTH-1:0] b_rdata,
  output logic             a_err,
  output logic             b_err,
  output logic [7:0]       watch_cnt
);

  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [1:0]       w_grant;
  logic             w_any;
  logic             w_we;
  logic [AW-1:0]    w_row;
  logic [AW-1:0]    w_col;
  logic [AW-1:0]    w_col_m1;
  logic [WIDTH-1:0] w_wdata;
  logic             w_valid;
  logic [RW-1:0]    w_row_idx;
  logic [CW-1:0]    w_col_idx;
  logic [WIDTH-1:0] w_cell;
  logic             w_watch_hit;

  logic [WIDTH-1:0] r_mem [ROWS][COLS];

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   ({b_req, a_req}),
    .o_grant (w_grant)
  );

  assign a_ack = w_grant[0];
  assign b_ack = w_grant[1];
  assign w_any = |w_grant;

  always_comb begin
    w_we    = w_grant[1] ? b_we    : a_we;
    w_row   = w_grant[1] ? b_row   : a_row;
    w_col   = w_grant[1] ? b_col   : a_col;
    w_wdata = w_grant[1] ? b_wdata : a_wdata;
  end

  // Indices are truncated only for the table lookup; w_valid gates every use of them.
  always_comb begin
    w_valid     = in_range(ADDR_MAX_W'(w_row), ADDR_MAX_W'(w_col), ROWS, COLS);
    w_col_m1    = w_col - AW'(1);
    w_row_idx   = w_row[RW-1:0];
    w_col_idx   = w_col_m1[CW-1:0];
    w_cell      = r_mem[w_row_idx][w_col_idx];
    w_watch_hit = w_any && w_we && w_valid &&
                  (w_row == AW'(WATCH_ROW)) && (w_col == AW'(WATCH_COL)) &&
                  (w_wdata[WATCH_BIT] != w_cell[WATCH_BIT]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          r_mem[RW'(r)][CW'(c)] <= '0;
      watch_cnt <= '0;
    end else if (w_any && w_we && w_valid) begin
      r_mem[w_row_idx][w_col_idx] <= w_wdata;
      if (w_watch_hit) watch_cnt <= watch_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_err    <= 1'b0;
      b_err    <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= w_grant[0] & ~w_we;
      b_rvalid <= w_grant[1] & ~w_we;
      a_err    <= w_grant[0] & ~w_valid;
      b_err    <= w_grant[1] & ~w_valid;
      if (w_grant[0] && !w_we) a_rdata <= w_valid ? w_cell : '0;
      if (w_grant[1] && !w_we) b_rdata <= w_valid ? w_cell : '0;
    end
  end

endmodule
